// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection and a pipeline-fill counter.
// Optional feature: define IDEX_FILL_COUNTER_EN to build the fill counter register;
// without it pcsrc_counter is tied permanently to FILL_MAX (forwarding always enabled).
module idex_hazard_stage #(
    parameter int          XLEN     = 32,
    parameter logic [2:0]  FILL_MAX = 3'b100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_uses_rs2,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic            flush,
    output logic [4:0]      idex_rs1,
    output logic [4:0]      idex_rs2,
    output logic [4:0]      idex_rd,
    output logic [XLEN-1:0] idex_rs1_data,
    output logic [XLEN-1:0] idex_rs2_data,
    output logic [XLEN-1:0] idex_imm,
    output logic            idex_alusrc,
    output logic            idex_regwrite,
    output logic            idex_memread,
    output logic            idex_memwrite,
    output logic            idex_memtoreg,
    output logic            stall,
    output logic [2:0]      pcsrc_counter
);

    logic rs1_hit;
    logic rs2_hit;
    logic bubble;

    // Load in EX whose destination is read by the instruction in ID; x0 never matches,
    // and a flush makes the stall pointless since the ID instruction is discarded.
    always_comb begin
        rs1_hit = (idex_rd == id_rs1);
        rs2_hit = id_uses_rs2 & (idex_rd == id_rs2);
        stall   = idex_memread & (idex_rd != 5'd0) & (rs1_hit | rs2_hit) & ~flush;
        bubble  = stall | flush;
    end

    // Pipeline register: indices and operands always load, control and rd are zeroed on a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_rs1      <= 5'd0;
            idex_rs2      <= 5'd0;
            idex_rd       <= 5'd0;
            idex_rs1_data <= '0;
            idex_rs2_data <= '0;
            idex_imm      <= '0;
            idex_alusrc   <= 1'b0;
            idex_regwrite <= 1'b0;
            idex_memread  <= 1'b0;
            idex_memwrite <= 1'b0;
            idex_memtoreg <= 1'b0;
        end else begin
            idex_rs1      <= id_rs1;
            idex_rs2      <= id_rs2;
            idex_rs1_data <= id_rs1_data;
            idex_rs2_data <= id_rs2_data;
            idex_imm      <= id_imm;
            if (bubble) begin
                idex_rd       <= 5'd0;
                idex_alusrc   <= 1'b0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
                idex_memwrite <= 1'b0;
                idex_memtoreg <= 1'b0;
            end else begin
                idex_rd       <= id_rd;
                idex_alusrc   <= id_alusrc;
                idex_regwrite <= id_regwrite;
                idex_memread  <= id_memread;
                idex_memwrite <= id_memwrite;
                idex_memtoreg <= id_memtoreg;
            end
        end
    end

`ifdef IDEX_FILL_COUNTER_EN
    logic [2:0] fill_count;

    // Cycles since the last flush/reset, saturating; a flush wins even when already saturated.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            fill_count <= 3'd0;
        end else if (fill_count < FILL_MAX) begin
            fill_count <= fill_count + 3'd1;
        end
    end

    assign pcsrc_counter = fill_count;
`else
    assign pcsrc_counter = FILL_MAX;
`endif

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed self-checking bench for idex_hazard_stage (default XLEN=32, FILL_MAX=4).
module tb_idex_hazard_stage;

`ifdef IDEX_FILL_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_uses_rs2, id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        flush;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [31:0] idex_rs1_data, idex_rs2_data, idex_imm;
    logic        idex_alusrc, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg;
    logic        stall;
    logic [2:0]  pcsrc_counter;

    int testsRun = 0;
    int testsFailed = 0;

    idex_hazard_stage #(.XLEN(32), .FILL_MAX(3'b100)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_uses_rs2(id_uses_rs2), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .flush(flush),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm),
        .idex_alusrc(idex_alusrc), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg),
        .stall(stall), .pcsrc_counter(pcsrc_counter)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected fill counter value: counts in the enabled build, pinned to FILL_MAX otherwise
    function automatic logic [31:0] expCnt(input int k);
        return CNT_EN ? 32'(k) : 32'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the decode-stage instruction fields; loads also set memtoreg
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic usesRs2, input logic memRead, input logic regWrite);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_uses_rs2 = usesRs2;
        id_memread  = memRead;
        id_memtoreg = memRead;
        id_regwrite = regWrite;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, "_rd"}, 32'(idex_rd), 32'd0);
        checkOutput({tag, "_regwrite"}, 32'(idex_regwrite), 32'd0);
        checkOutput({tag, "_memread"}, 32'(idex_memread), 32'd0);
        checkOutput({tag, "_memtoreg"}, 32'(idex_memtoreg), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_alusrc = 1'b0; id_memwrite = 1'b0;
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset sequence: two reset edges, then the fill counter walks up and saturates
        tick(); tick();
        checkOutput("rst_rd", 32'(idex_rd), 32'd0);
        checkOutput("rst_regwrite", 32'(idex_regwrite), 32'd0);
        checkOutput("rst_memread", 32'(idex_memread), 32'd0);
        checkOutput("rst_rs1_data", idex_rs1_data, 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_cnt0", 32'(pcsrc_counter), expCnt(0));
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput($sformatf("fill_cnt_edge%0d", k), 32'(pcsrc_counter), expCnt(k > 4 ? 4 : k));
        end

        // Load-use hazard on rs1: lw x5, then add x6 reading x5
        applyStimulus(5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("lw_memread", 32'(idex_memread), 32'd1);
        checkOutput("lw_rd", 32'(idex_rd), 32'd5);
        applyStimulus(5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1);
        checkOutput("lu_stall", 32'(stall), 32'd1);
        tick();
        checkBubble("lu_bubble");
        checkOutput("lu_bubble_rs1", 32'(idex_rs1), 32'd5);
        checkOutput("lu_stall_clear", 32'(stall), 32'd0);
        checkOutput("lu_cnt_unaffected", 32'(pcsrc_counter), expCnt(4));
        tick();
        checkOutput("lu_add_rd", 32'(idex_rd), 32'd6);
        checkOutput("lu_add_regwrite", 32'(idex_regwrite), 32'd1);

        // rs2 match only stalls when the instruction actually reads rs2
        applyStimulus(5'd1, 5'd2, 5'd7, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(5'd3, 5'd7, 5'd8, 1'b0, 1'b0, 1'b1);
        checkOutput("rs2_unused_stall", 32'(stall), 32'd0);
        applyStimulus(5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1);
        checkOutput("rs2_used_stall", 32'(stall), 32'd1);
        tick();
        checkBubble("rs2_bubble");
        checkOutput("rs2_bubble_rs2", 32'(idex_rs2), 32'd7);

        // x0 destination never stalls
        applyStimulus(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("x0_memread", 32'(idex_memread), 32'd1);
        applyStimulus(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1);
        checkOutput("x0_stall", 32'(stall), 32'd0);
        tick();
        checkOutput("x0_next_rd", 32'(idex_rd), 32'd4);

        // Flush on the same edge as a hazard: flush wins, counter clears even when saturated
        applyStimulus(5'd1, 5'd2, 5'd9, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(5'd9, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1);
        checkOutput("fl_pre_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        #1;
        checkOutput("fl_stall_masked", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        checkBubble("fl_bubble");
        checkOutput("fl_cnt_zero", 32'(pcsrc_counter), expCnt(0));
        checkOutput("fl_post_stall", 32'(stall), 32'd0);
        tick();
        checkOutput("fl_cnt_one", 32'(pcsrc_counter), expCnt(1));
        checkOutput("fl_resume_rd", 32'(idex_rd), 32'd10);

        // Passthrough of operands and control with one cycle latency
        id_rs1_data = 32'hDEADBEEF;
        id_rs2_data = 32'h12345678;
        id_imm      = 32'hFFFFF800;
        id_alusrc   = 1'b1;
        id_memwrite = 1'b1;
        applyStimulus(5'd1, 5'd31, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("pt_rs1_data", idex_rs1_data, 32'hDEADBEEF);
        checkOutput("pt_rs2_data", idex_rs2_data, 32'h12345678);
        checkOutput("pt_imm", idex_imm, 32'hFFFFF800);
        checkOutput("pt_alusrc", 32'(idex_alusrc), 32'd1);
        checkOutput("pt_memwrite", 32'(idex_memwrite), 32'd1);
        checkOutput("pt_rs2", 32'(idex_rs2), 32'd31);
        checkOutput("pt_rd", 32'(idex_rd), 32'd3);
        id_alusrc = 1'b0;
        id_memwrite = 1'b0;

        // Reset in the middle of a stall leaves no residue
        applyStimulus(5'd1, 5'd2, 5'd11, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(5'd11, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1);
        checkOutput("mr_pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkBubble("mr_reset");
        checkOutput("mr_rs1", 32'(idex_rs1), 32'd0);
        checkOutput("mr_imm", idex_imm, 32'd0);
        checkOutput("mr_stall", 32'(stall), 32'd0);
        checkOutput("mr_cnt", 32'(pcsrc_counter), expCnt(0));
        tick();
        checkOutput("mr_resume_rd", 32'(idex_rd), 32'd12);
        checkOutput("mr_resume_cnt", 32'(pcsrc_counter), expCnt(1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
